sort_checker: RTL and testbench
===============================

# sort_checker

Avalon-ST sink that consumes the sorted packet stream produced by the sorting block and checks it in-line. It checks three things for every packet: SOP/EOP framing, non-decreasing (unsigned) data order, and length. It emits a one-cycle result record per packet and keeps saturating packet and error counters. It also includes an optional pseudo-random backpressure generator, so the bench can exercise the upstream source's handling of `src_ready_i`.

## Interface
- `DWIDTH`, 8, width of the data beat
- `MAX_PKT_LEN`, 256, largest legal packet length in beats
- `BP_SEED`, 8'hA5, non-zero reset seed of the backpressure LFSR
- `LEN_W` (derived), `$clog2(MAX_PKT_LEN+2)`, width of the length counter
- `clk_i`  in  1  single clock; all logic is on its rising edge
- `arst_n_i`  in  1  asynchronous, active-low reset
- `snk_data_i`  in  DWIDTH  beat data
- `snk_startofpacket_i`  in  1  SOP
- `snk_endofpacket_i`  in  1  EOP
- `snk_valid_i`  in  1  beat valid
- `snk_ready_o`  out  1  sink ready (registered)
- `bp_en_i`  in  1  1 = ready follows the LFSR; 0 = ready is always 1
- `cnt_clr_i`  in  1  synchronous clear of both counters
- `res_valid_o`  out  1  one-cycle pulse: a result record is available
- `res_len_o`  out  LEN_W  beats in the reported packet, saturating at MAX_PKT_LEN+1
- `res_err_o`  out  4  error flags: [0] order, [1] missing SOP, [2] duplicate SOP, [3] too long
- `pkt_cnt_o`  out  16  count of results reported, saturating at 16'hFFFF
- `err_cnt_o`  out  16  count of results with `res_err_o` != 0, saturating at 16'hFFFF

## Operation
- **Accepted beat:** `snk_valid_i && snk_ready_o`. Beats that are not accepted are ignored entirely.
- **States:** IDLE_S, PKT_S, DROP_S.
- **IDLE_S:**
  - Accepted beat with SOP: set len=1, store the beat as the order reference `last`, clear the flags.
    - If EOP is also set, report the result at once (single-beat packet, len 1, no errors).
    - Otherwise go to PKT_S.
  - Accepted beat without SOP: set len=1 and flag[1].
    - If EOP is also set, report at once.
    - Otherwise go to DROP_S.
- **PKT_S, each accepted beat:**
  - len increments, saturating at MAX_PKT_LEN+1. When len passes MAX_PKT_LEN, set flag[3].
  - If `snk_data_i < last`, set flag[0]. Equal values are legal.
  - `last` is updated to the current beat.
  - If SOP is set, set flag[2]. The packet continues and len is not restarted.
  - On EOP: report the result and go to IDLE_S.
- **DROP_S:**
  - Count beats only; no order checking.
  - SOP on a beat here sets flag[2].
  - On EOP: report the result and go to IDLE_S.
- **Reporting** means that on the next cycle:
  - `res_valid_o` is 1 for one cycle.
  - `res_len_o` and `res_err_o` are loaded, and hold until the next report.
  - `pkt_cnt_o` increments; `err_cnt_o` increments if any flag is set.
- **Counter clear:** `cnt_clr_i` takes priority over a same-cycle increment; both counters become 0.
- **Backpressure:**
  - The 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advances every cycle.
  - `snk_ready_o` is registered as `!bp_en_i || lfsr_next[0]`.

## Timing
- **Reset values:**
  - `snk_ready_o`=0, `res_valid_o`=0, `res_len_o`=0, `res_err_o`=0, both counters 0.
  - LFSR=BP_SEED, state=IDLE_S.
- `snk_ready_o` first rises on the first clock edge after `arst_n_i` deasserts.
- **Result latency:** `res_valid_o` is asserted exactly 1 cycle after the accepted EOP beat.
  - Back-to-back single-beat packets produce a `res_valid_o` pulse on consecutive cycles.
- **Ready response:** a change on `bp_en_i` affects `snk_ready_o` 1 cycle later.
- **Reset mid-packet:** all in-flight state is discarded and no result is reported for the partial packet.
- **len saturation:** len sticks at MAX_PKT_LEN+1 and never wraps. A 1000-beat packet reports `res_len_o`=MAX_PKT_LEN+1 with flag[3] set.
- **Counters:** stick at 16'hFFFF.

## Structure
- **Package `sort_pkg`:**
  - `state_t` enum: IDLE_S, PKT_S, DROP_S.
  - Localparams `ERR_ORDER`=0, `ERR_NO_SOP`=1, `ERR_DUP_SOP`=2, `ERR_LONG`=3.
  - LFSR tap mask 8'hB8.
- **Sub-module `lfsr_bp`:**
  - Parameter: seed.
  - Ports: `clk_i`, `arst_n_i`, `en_i`, `ready_o`.
  - Contains the LFSR and the registered ready output.
- **Top level:** FSM, length/order datapath, result registers and counters.

## Test plan
- **Sorted packet:** SOP beat 3, then 3, 7, 200 with EOP, `bp_en_i`=0 → one cycle after EOP: `res_valid_o`=1, `res_len_o`=4, `res_err_o`=0, `pkt_cnt_o`=1, `err_cnt_o`=0.
- **Order error:** packet 10, 5, 9 → `res_len_o`=3, `res_err_o`=4'b0001, `err_cnt_o`=1.
- **Framing errors:**
  - Beat 1 without SOP, then 2 with EOP → `res_len_o`=2, `res_err_o`=4'b0010.
  - Packet with a second SOP on beat 3 of 5 → `res_len_o`=5, `res_err_o`=4'b0100.
- **Length:** 257-beat ascending packet with MAX_PKT_LEN=256 → `res_len_o`=257, `res_err_o`=4'b1000.
- **Single-beat packets:** two SOP+EOP beats on consecutive cycles → two consecutive `res_valid_o` pulses, each with len 1.
- **Backpressure and reset:**
  - `bp_en_i`=1 with valid held high → accepted beats match the LFSR pattern (first ready values derived from seed 8'hA5) and the results match the unthrottled run.
  - Assert `arst_n_i`=0 mid-packet → no `res_valid_o` pulse, all outputs return to their reset values.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the sort_checker slice.
//   state_t    - packet-tracking FSM states
//   ERR_*      - bit positions inside the 4-bit result error vector
//   LFSR_TAPS  - feedback tap mask of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    PKT_S  = 2'd1,
    DROP_S = 2'd2
  } state_t;

  localparam int ERR_ORDER   = 0;
  localparam int ERR_NO_SOP  = 1;
  localparam int ERR_DUP_SOP = 2;
  localparam int ERR_LONG    = 3;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr_bp.sv
// lfsr_bp: pseudo-random backpressure source for the sink ready signal.
//   clk_i    - clock, rising edge
//   arst_n_i - asynchronous active-low reset (LFSR returns to SEED, ready to 0)
//   en_i     - 1: ready follows the LFSR output bit; 0: ready is held high
//   ready_o  - registered ready
module lfsr_bp
  import sort_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic en_i,
  output logic ready_o
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       ready_q, ready_d;
  logic       fb;

  // The LFSR free-runs every cycle regardless of en_i, so the pattern seen
  // after enabling depends only on the number of cycles since reset.
  always_comb begin
    fb      = ^(lfsr_q & LFSR_TAPS);
    lfsr_d  = {lfsr_q[6:0], fb};
    ready_d = !en_i || lfsr_d[0];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lfsr_q  <= SEED;
      ready_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/sort_checker.sv
// sort_checker: Avalon-ST sink that checks framing, non-decreasing order and
// length of each packet and reports a one-cycle result record per packet.
//   clk_i / arst_n_i            - clock and asynchronous active-low reset
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i - sink beat inputs
//   snk_ready_o                 - registered sink ready (from lfsr_bp)
//   bp_en_i                     - enable pseudo-random backpressure
//   cnt_clr_i                   - synchronous clear of both counters
//   res_valid_o                 - one-cycle pulse per reported packet
//   res_len_o / res_err_o       - length and error flags of last report
//   pkt_cnt_o / err_cnt_o       - saturating report / errored-report counters
module sort_checker
  import sort_pkg::*;
#(
  parameter  int         DWIDTH      = 8,
  parameter  int         MAX_PKT_LEN = 256,
  parameter  logic [7:0] BP_SEED     = 8'hA5,
  localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 2)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              bp_en_i,
  input  logic              cnt_clr_i,
  output logic              res_valid_o,
  output logic [LEN_W-1:0]  res_len_o,
  output logic [3:0]        res_err_o,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_PKT_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PKT_LEN);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_inc;
  logic [3:0]        flags_q, flags_d;
  logic [DWIDTH-1:0] last_q, last_d;
  logic              res_valid_q, res_valid_d;
  logic [LEN_W-1:0]  res_len_q, res_len_d;
  logic [3:0]        res_err_q, res_err_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              acc;
  logic              report;

  lfsr_bp #(
    .SEED(BP_SEED)
  ) u_lfsr_bp (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .en_i    (bp_en_i),
    .ready_o (snk_ready_o)
  );

  always_comb begin
    acc     = snk_valid_i && snk_ready_o;
    len_inc = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    state_d = state_q;
    len_d   = len_q;
    flags_d = flags_q;
    last_d  = last_q;
    report  = 1'b0;

    if (acc) begin
      unique case (state_q)
        IDLE_S: begin
          len_d   = LEN_W'(1);
          last_d  = snk_data_i;
          flags_d = 4'b0000;
          if (!snk_startofpacket_i) flags_d[ERR_NO_SOP] = 1'b1;
          if (snk_endofpacket_i) report = 1'b1;
          else state_d = snk_startofpacket_i ? PKT_S : DROP_S;
        end
        PKT_S: begin
          len_d  = len_inc;
          last_d = snk_data_i;
          if (len_inc > LEN_MAX)     flags_d[ERR_LONG]    = 1'b1;
          if (snk_data_i < last_q)   flags_d[ERR_ORDER]   = 1'b1;
          // A stray SOP is flagged but the packet is not restarted.
          if (snk_startofpacket_i)   flags_d[ERR_DUP_SOP] = 1'b1;
          if (snk_endofpacket_i) begin
            report  = 1'b1;
            state_d = IDLE_S;
          end
        end
        DROP_S: begin
          // Packet already known to be misframed: count beats, skip ordering.
          len_d = len_inc;
          if (len_inc > LEN_MAX)     flags_d[ERR_LONG]    = 1'b1;
          if (snk_startofpacket_i)   flags_d[ERR_DUP_SOP] = 1'b1;
          if (snk_endofpacket_i) begin
            report  = 1'b1;
            state_d = IDLE_S;
          end
        end
        default: state_d = IDLE_S;
      endcase
    end

    res_valid_d = report;
    res_len_d   = report ? len_d   : res_len_q;
    res_err_d   = report ? flags_d : res_err_q;

    // Clear wins over a same-cycle increment.
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr_i) begin
      pkt_cnt_d = 16'h0000;
      err_cnt_d = 16'h0000;
    end else if (report) begin
      if (pkt_cnt_q != 16'hFFFF)                    pkt_cnt_d = pkt_cnt_q + 16'd1;
      if ((flags_d != 4'b0000) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE_S;
      len_q       <= '0;
      flags_q     <= 4'b0000;
      res_valid_q <= 1'b0;
      res_len_q   <= '0;
      res_err_q   <= 4'b0000;
      pkt_cnt_q   <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      res_len_q   <= res_len_d;
      res_err_q   <= res_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Order reference is pure data and is always rewritten on the first beat.
  always_ff @(posedge clk_i) begin
    last_q <= last_d;
  end

  assign res_valid_o = res_valid_q;
  assign res_len_o   = res_len_q;
  assign res_err_o   = res_err_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_sort_checker.sv
// tb_sort_checker: directed self-checking bench for sort_checker.
module tb_sort_checker;

  logic        clk;
  logic        arst_n;
  logic [7:0]  snk_data;
  logic        snk_sop;
  logic        snk_eop;
  logic        snk_valid;
  logic        snk_ready;
  logic        bp_en;
  logic        cnt_clr;
  logic        res_valid;
  logic [8:0]  res_len;
  logic [3:0]  res_err;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference backpressure model built from the polynomial description.
  logic [7:0] m_lfsr;
  logic       m_ready;

  sort_checker #(
    .DWIDTH     (8),
    .MAX_PKT_LEN(256),
    .BP_SEED    (8'hA5)
  ) dut (
    .clk_i              (clk),
    .arst_n_i           (arst_n),
    .snk_data_i         (snk_data),
    .snk_startofpacket_i(snk_sop),
    .snk_endofpacket_i  (snk_eop),
    .snk_valid_i        (snk_valid),
    .snk_ready_o        (snk_ready),
    .bp_en_i            (bp_en),
    .cnt_clr_i          (cnt_clr),
    .res_valid_o        (res_valid),
    .res_len_o          (res_len),
    .res_err_o          (res_err),
    .pkt_cnt_o          (pkt_cnt),
    .err_cnt_o          (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_lfsr  <= 8'hA5;
      m_ready <= 1'b0;
    end else begin
      m_lfsr  <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_ready <= !bp_en || (^(m_lfsr & 8'hB8));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    acc       = 1'b0;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    snk_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      chk("ready_vs_lfsr", {31'd0, snk_ready}, {31'd0, m_ready});
      acc = snk_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle_cycle();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_result(input string tag, input int len, input int err,
                            input int pc, input int ec);
    chk({tag, "_valid"},   {31'd0, res_valid}, 32'd1);
    chk({tag, "_len"},     {23'd0, res_len},   len);
    chk({tag, "_err"},     {28'd0, res_err},   err);
    chk({tag, "_pkt_cnt"}, {16'd0, pkt_cnt},   pc);
    chk({tag, "_err_cnt"}, {16'd0, err_cnt},   ec);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   {31'd0, snk_ready}, 32'd0);
    chk({tag, "_valid"},   {31'd0, res_valid}, 32'd0);
    chk({tag, "_len"},     {23'd0, res_len},   32'd0);
    chk({tag, "_err"},     {28'd0, res_err},   32'd0);
    chk({tag, "_pkt_cnt"}, {16'd0, pkt_cnt},   32'd0);
    chk({tag, "_err_cnt"}, {16'd0, err_cnt},   32'd0);
  endtask

  initial begin
    logic [6:0] bp_seq;
    bp_seq    = 7'b1110010;  // ready after reset with bp on, bit k = cycle k
    arst_n    = 1'b0;
    snk_data  = 8'd0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    snk_valid = 1'b0;
    bp_en     = 1'b0;
    cnt_clr   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    arst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, snk_ready}, 32'd1);

    // Sorted packet 3,3,7,200
    beat(8'd3, 1'b1, 1'b0);
    beat(8'd3, 1'b0, 1'b0);
    beat(8'd7, 1'b0, 1'b0);
    beat(8'd200, 1'b0, 1'b1);
    chk_result("sorted", 4, 0, 1, 0);
    idle_cycle();
    chk("sorted_pulse_end", {31'd0, res_valid}, 32'd0);
    chk("sorted_len_hold", {23'd0, res_len}, 32'd4);

    // Order error 10,5,9
    beat(8'd10, 1'b1, 1'b0);
    beat(8'd5, 1'b0, 1'b0);
    beat(8'd9, 1'b0, 1'b1);
    chk_result("order", 3, 1, 2, 1);
    idle_cycle();

    // Missing SOP: 1, 2+EOP
    beat(8'd1, 1'b0, 1'b0);
    beat(8'd2, 1'b0, 1'b1);
    chk_result("no_sop", 2, 2, 3, 2);
    idle_cycle();

    // Duplicate SOP on beat 3 of 5
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    beat(8'd3, 1'b1, 1'b0);
    beat(8'd4, 1'b0, 1'b0);
    beat(8'd5, 1'b0, 1'b1);
    chk_result("dup_sop", 5, 4, 4, 3);
    idle_cycle();

    // 257-beat non-decreasing packet
    for (int i = 0; i < 257; i++) beat(8'(i / 2), (i == 0), (i == 256));
    chk_result("too_long", 257, 8, 5, 4);
    idle_cycle();

    // Back-to-back single-beat packets
    beat(8'd5, 1'b1, 1'b1);
    chk_result("single_a", 1, 0, 6, 4);
    beat(8'd6, 1'b1, 1'b1);
    chk_result("single_b", 1, 0, 7, 4);
    idle_cycle();
    chk("single_pulse_end", {31'd0, res_valid}, 32'd0);

    // Clear wins over a same-cycle increment
    cnt_clr = 1'b1;
    beat(8'd9, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk_result("clr_prio", 1, 0, 0, 0);
    beat(8'd9, 1'b1, 1'b1);
    chk_result("after_clr", 1, 0, 1, 0);
    idle_cycle();

    // Reset, then backpressure from the seeded LFSR
    bp_en  = 1'b1;
    arst_n = 1'b0;
    #1;
    chk_reset_outputs("reset2");
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("bp_seq%0d", k), {31'd0, snk_ready}, {31'd0, bp_seq[k]});
    end
    beat(8'd3, 1'b1, 1'b0);
    beat(8'd3, 1'b0, 1'b0);
    beat(8'd7, 1'b0, 1'b0);
    beat(8'd200, 1'b0, 1'b1);
    chk_result("bp_sorted", 4, 0, 1, 0);
    bp_en = 1'b0;
    idle_cycle();
    chk("bp_off_ready", {31'd0, snk_ready}, 32'd1);

    // Reset in the middle of a packet
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    snk_valid = 1'b0;
    arst_n    = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_reset_no_pulse", {31'd0, res_valid}, 32'd0);
    end
    // A fresh SOP must start a clean packet (no duplicate-SOP carry-over)
    beat(8'd4, 1'b1, 1'b1);
    chk_result("post_reset", 1, 0, 1, 0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
